// File: rtl/mips_avalon_lsu_if.sv
// Core-side request/response and Avalon-MM master bundles
// for the MIPS load/store bus unit.
interface mips_avalon_lsu_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, busy
  );
endinterface

interface mips_avalon_lsu_avm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, read, write,
    output writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_avalon_lsu.sv
// Single-outstanding load/store unit bridging the MIPS core
// to an Avalon-MM master with lane steering and timeout.
module mips_avalon_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input logic                   clk,
  input logic                   reset,
  mips_avalon_lsu_req_if.slave  core,
  mips_avalon_lsu_avm_if.master avm
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  state_t state;

  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [LANE_W-1:0] r_off;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;

  logic              ready_q;
  logic              busy_q;
  logic              rv_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        err_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] wd_q;
  logic [BE_W-1:0]   be_q;

  logic [LANE_W-1:0] off_in;
  logic              mis;
  logic [BE_W-1:0]   be_in;
  logic [DATA_W-1:0] wd_in;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] keep;
  logic              sb;
  logic [DATA_W-1:0] ext;
  logic              tmo;

  assign off_in  = core.req_addr[LANE_W-1:0];
  assign cnt_inc = cnt + CNT_W'(1);
  assign tmo     = (TIMEOUT != 0) &&
                   (cnt_inc == CNT_W'(TIMEOUT));

  // Alignment check on the incoming request.
  always_comb begin
    mis = 1'b0;
    unique case (core.req_size)
      2'd0: mis = 1'b0;
      2'd1: mis = core.req_addr[0];
      2'd2: mis = |core.req_addr[1:0];
      default:
        mis = (DATA_W == 32) || (|core.req_addr[2:0]);
    endcase
  end

  // Lane enables and replicated store data.
  always_comb begin
    be_in = '0;
    wd_in = '0;
    unique case (core.req_size)
      2'd0: begin
        be_in = BE_W'(1) << off_in;
        wd_in = {BE_W{core.req_wdata[7:0]}};
      end
      2'd1: begin
        be_in = BE_W'(2'b11) << off_in;
        wd_in = {(BE_W/2){core.req_wdata[15:0]}};
      end
      2'd2: begin
        be_in = BE_W'(4'hF) << off_in;
        wd_in = {(BE_W/4){core.req_wdata[31:0]}};
      end
      default: begin
        be_in = '1;
        wd_in = core.req_wdata;
      end
    endcase
  end

  // Shift the addressed lanes down and extend.
  always_comb begin
    sh   = avm.readdata >> {r_off, 3'b000};
    keep = '1;
    sb   = 1'b0;
    unique case (r_size)
      2'd0: begin
        keep = DATA_W'(8'hFF);
        sb   = sh[7];
      end
      2'd1: begin
        keep = DATA_W'(16'hFFFF);
        sb   = sh[15];
      end
      2'd2: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        sb   = sh[31];
      end
      default: begin
        keep = '1;
        sb   = 1'b0;
      end
    endcase
    ext = (sh & keep) |
          ((r_signed && sb) ? ~keep : '0);
  end

  // Request/bus/response sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_off    <= '0;
      cnt      <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 2'd0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wd_q     <= '0;
      be_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core.req_valid) begin
            r_write  <= core.req_write;
            r_size   <= core.req_size;
            r_signed <= core.req_signed;
            r_off    <= off_in;
            cnt      <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            if (mis) begin
              state   <= RESP;
              rv_q    <= 1'b1;
              err_q   <= 2'd1;
              rdata_q <= '0;
            end else begin
              state  <= BUS;
              addr_q <= {core.req_addr[ADDR_W-1:LANE_W],
                         {LANE_W{1'b0}}};
              be_q   <= be_in;
              wd_q   <= wd_in;
              rd_q   <= !core.req_write;
              wr_q   <= core.req_write;
            end
          end
        end
        BUS: begin
          if (!avm.waitrequest) begin
            state   <= RESP;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rv_q    <= 1'b1;
            err_q   <= 2'd0;
            rdata_q <= r_write ? '0 : ext;
          end else begin
            cnt <= cnt_inc;
            if (tmo) begin
              state   <= RESP;
              rd_q    <= 1'b0;
              wr_q    <= 1'b0;
              rv_q    <= 1'b1;
              err_q   <= 2'd2;
              rdata_q <= '0;
            end
          end
        end
        RESP: begin
          state   <= IDLE;
          rv_q    <= 1'b0;
          cnt     <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rv_q    <= 1'b0;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign core.req_ready  = ready_q;
  assign core.busy       = busy_q;
  assign core.resp_valid = rv_q;
  assign core.resp_rdata = rdata_q;
  assign core.resp_err   = err_q;

  assign avm.address    = addr_q;
  assign avm.read       = rd_q;
  assign avm.write      = wr_q;
  assign avm.writedata  = wd_q;
  assign avm.byteenable = be_q;

endmodule

// File: tb/tb_mips_avalon_lsu.sv
// Scoreboard bench for mips_avalon_lsu with a 32-bit and
// a 64-bit instance sharing one stimulus driver.
module tb_mips_avalon_lsu;

  typedef struct {
    logic [63:0] rd;
    logic [1:0]  err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic        req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        waitrequest;
  logic [63:0] readdata;

  int total = 0;
  int bad   = 0;

  exp_t q32[$];
  exp_t q64[$];

  mips_avalon_lsu_req_if #(.ADDR_W(32), .DATA_W(32)) c32();
  mips_avalon_lsu_avm_if #(.ADDR_W(32), .DATA_W(32)) a32();
  mips_avalon_lsu_req_if #(.ADDR_W(32), .DATA_W(64)) c64();
  mips_avalon_lsu_avm_if #(.ADDR_W(32), .DATA_W(64)) a64();

  mips_avalon_lsu #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)
  ) u32 (
    .clk(clk), .reset(reset), .core(c32), .avm(a32)
  );

  mips_avalon_lsu #(
    .ADDR_W(32), .DATA_W(64), .TIMEOUT(4)
  ) u64 (
    .clk(clk), .reset(reset), .core(c64), .avm(a64)
  );

  assign c32.req_valid   = req_valid & ~sel;
  assign c32.req_write   = req_write;
  assign c32.req_size    = req_size;
  assign c32.req_signed  = req_signed;
  assign c32.req_addr    = req_addr;
  assign c32.req_wdata   = req_wdata[31:0];
  assign a32.waitrequest = waitrequest;
  assign a32.readdata    = readdata[31:0];

  assign c64.req_valid   = req_valid & sel;
  assign c64.req_write   = req_write;
  assign c64.req_size    = req_size;
  assign c64.req_signed  = req_signed;
  assign c64.req_addr    = req_addr;
  assign c64.req_wdata   = req_wdata;
  assign a64.waitrequest = waitrequest;
  assign a64.readdata    = readdata;

  logic        rv_s, rd_s, wr_s, busy_s, ready_s;
  logic [31:0] addr_s;
  logic [7:0]  be_s;
  logic [63:0] wd_s;

  assign rv_s    = sel ? c64.resp_valid : c32.resp_valid;
  assign rd_s    = sel ? a64.read : a32.read;
  assign wr_s    = sel ? a64.write : a32.write;
  assign busy_s  = sel ? c64.busy : c32.busy;
  assign ready_s = sel ? c64.req_ready : c32.req_ready;
  assign addr_s  = sel ? a64.address : a32.address;
  assign be_s    = sel ? a64.byteenable
                       : {4'b0, a32.byteenable};
  assign wd_s    = sel ? a64.writedata
                       : {32'b0, a32.writedata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // 32-bit response monitor
  always @(negedge clk) begin : mon32
    exp_t e;
    if (reset && c32.resp_valid) begin
      if (q32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp32 act=1 exp=0");
      end else begin
        e = q32.pop_front();
        chk("rdata32", 64'(c32.resp_rdata), e.rd);
        chk("err32", 64'(c32.resp_err), 64'(e.err));
      end
    end
  end

  // 64-bit response monitor
  always @(negedge clk) begin : mon64
    exp_t e;
    if (reset && c64.resp_valid) begin
      if (q64.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp64 act=1 exp=0");
      end else begin
        e = q64.pop_front();
        chk("rdata64", c64.resp_rdata, e.rd);
        chk("err64", 64'(c64.resp_err), 64'(e.err));
      end
    end
  end

  task automatic run(
    input string       nm,
    input bit          s,
    input bit          w,
    input logic [1:0]  sz,
    input bit          sg,
    input logic [31:0] ad,
    input logic [63:0] wd,
    input logic [63:0] rd,
    input int          nw,
    input logic [63:0] erd,
    input logic [1:0]  eerr,
    input int          elat,
    input logic [7:0]  ebe,
    input logic [31:0] eaddr,
    input logic [63:0] ewd
  );
    int   n;
    int   st;
    exp_t e;
    sel         = s;
    req_write   = w;
    req_size    = sz;
    req_signed  = sg;
    req_addr    = ad;
    req_wdata   = wd;
    readdata    = rd;
    waitrequest = (nw > 0);
    req_valid   = 1'b1;
    chk({nm, "_ready"}, 64'(ready_s), 64'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = '1;
    req_write  = ~w;
    req_signed = ~sg;
    e.rd  = erd;
    e.err = eerr;
    if (s) q64.push_back(e);
    else   q32.push_back(e);
    n  = 0;
    st = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rv_s) break;
      if (n == 1) begin
        chk({nm, "_busy"}, 64'(busy_s), 64'd1);
        chk({nm, "_nrdy"}, 64'(ready_s), 64'd0);
      end
      if (rd_s || wr_s) begin
        st++;
        chk({nm, "_rw"}, {62'b0, rd_s, wr_s},
            w ? 64'd1 : 64'd2);
        chk({nm, "_addr"}, 64'(addr_s), 64'(eaddr));
        chk({nm, "_be"}, 64'(be_s), 64'(ebe));
        if (w) chk({nm, "_wd"}, wd_s, ewd);
      end
      @(posedge clk);
      #1;
      waitrequest = (n < nw);
    end
    chk({nm, "_lat"}, 64'(n), 64'(elat));
    chk({nm, "_strobes"}, 64'(st), 64'(elat - 1));
    chk({nm, "_rw_resp"}, {62'b0, rd_s, wr_s}, 64'd0);
    @(posedge clk);
    #1;
    waitrequest = 1'b0;
    chk({nm, "_idle"}, 64'(ready_s), 64'd1);
  endtask

  initial begin
    reset       = 1'b0;
    sel         = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_signed  = 1'b0;
    req_size    = 2'd0;
    req_addr    = '0;
    req_wdata   = '0;
    waitrequest = 1'b0;
    readdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rv32", 64'(c32.resp_valid), 64'd0);
    chk("rst_rdata32", 64'(c32.resp_rdata), 64'd0);
    chk("rst_err32", 64'(c32.resp_err), 64'd0);
    chk("rst_rw32", {62'b0, a32.read, a32.write}, 64'd0);
    chk("rst_addr32", 64'(a32.address), 64'd0);
    chk("rst_wd32", 64'(a32.writedata), 64'd0);
    chk("rst_be32", 64'(a32.byteenable), 64'd0);
    chk("rst_busy32", 64'(c32.busy), 64'd0);
    chk("rst_rdy32", 64'(c32.req_ready), 64'd1);
    chk("rst_rv64", 64'(c64.resp_valid), 64'd0);
    chk("rst_rw64", {62'b0, a64.read, a64.write}, 64'd0);
    chk("rst_be64", 64'(a64.byteenable), 64'd0);
    chk("rst_rdy64", 64'(c64.req_ready), 64'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run("lb_s", 0, 0, 2'd0, 1, 32'h1003, 0,
        64'h80FF_FFFF, 0, 64'hFFFF_FF80, 0, 2,
        8'b1000, 32'h1000, 0);
    run("sh_w3", 0, 1, 2'd1, 0, 32'h2002, 64'hBEEF,
        0, 3, 0, 0, 5,
        8'b1100, 32'h2000, 64'hBEEF_BEEF);
    run("lw_mis", 0, 0, 2'd2, 0, 32'h0006, 0,
        64'h1234_5678, 0, 0, 1, 1, 0, 0, 0);
    run("lw_tmo", 0, 0, 2'd2, 0, 32'h0010, 0,
        64'h1234_5678, 100, 0, 2, 5,
        8'hF, 32'h0010, 0);
    run("lbu", 0, 0, 2'd0, 0, 32'h1001, 0,
        64'h1234_5678, 0, 64'h56, 0, 2,
        8'b0010, 32'h1000, 0);
    run("lh_s", 0, 0, 2'd1, 1, 32'h2000, 0,
        64'h0000_8001, 0, 64'hFFFF_8001, 0, 2,
        8'b0011, 32'h2000, 0);
    run("sb", 0, 1, 2'd0, 0, 32'h3001, 64'hA5,
        0, 0, 0, 0, 2,
        8'b0010, 32'h3000, 64'hA5A5_A5A5);
    run("sw_w1", 0, 1, 2'd2, 0, 32'h4000,
        64'hDEAD_BEEF, 0, 1, 0, 0, 3,
        8'hF, 32'h4000, 64'hDEAD_BEEF);
    run("lw", 0, 0, 2'd2, 1, 32'h0004, 0,
        64'hCAFE_F00D, 0, 64'hCAFE_F00D, 0, 2,
        8'hF, 32'h0004, 0);
    run("lh_mis", 0, 0, 2'd1, 0, 32'h5001, 0,
        0, 0, 0, 1, 1, 0, 0, 0);
    run("ld_on32", 0, 0, 2'd3, 0, 32'h0008, 0,
        0, 0, 0, 1, 1, 0, 0, 0);

    run("lhu64", 1, 0, 2'd1, 0, 32'h1006, 0,
        64'h9ABC_0000_0000_0000, 0, 64'h9ABC, 0, 2,
        8'hC0, 32'h1000, 0);
    run("ld64", 1, 0, 2'd3, 1, 32'h1008, 0,
        64'h0123_4567_89AB_CDEF, 0,
        64'h0123_4567_89AB_CDEF, 0, 2,
        8'hFF, 32'h1008, 0);
    run("lw_s64", 1, 0, 2'd2, 1, 32'h2004, 0,
        64'h8765_4321_0000_0000, 0,
        64'hFFFF_FFFF_8765_4321, 0, 2,
        8'hF0, 32'h2000, 0);
    run("sw64", 1, 1, 2'd2, 0, 32'h0018,
        64'h1122_3344, 0, 0, 0, 0, 2,
        8'h0F, 32'h0018, 64'h1122_3344_1122_3344);
    run("ld_mis64", 1, 0, 2'd3, 0, 32'h1004, 0,
        0, 0, 0, 1, 1, 0, 0, 0);
    run("sb64", 1, 1, 2'd0, 0, 32'h0007, 64'h5A,
        0, 0, 0, 0, 2,
        8'h80, 32'h0000, 64'h5A5A_5A5A_5A5A_5A5A);
    run("lbu64", 1, 0, 2'd0, 0, 32'h0003, 0,
        64'h0000_0000_F000_0000, 0, 64'hF0, 0, 2,
        8'h08, 32'h0000, 0);

    sel         = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd2;
    req_signed  = 1'b0;
    req_addr    = 32'h40;
    waitrequest = 1'b1;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_read", 64'(a32.read), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_read_drop", 64'(a32.read), 64'd0);
    chk("mid_busy", 64'(c32.busy), 64'd0);
    chk("mid_ready", 64'(c32.req_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    reset       = 1'b1;
    waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_ready", 64'(c32.req_ready), 64'd1);
    chk("post_read", 64'(a32.read), 64'd0);

    run("after_rst", 0, 0, 2'd1, 0, 32'h0042, 0,
        64'h7F00_0000, 0, 64'h7F00, 0, 2,
        8'b1100, 32'h0040, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("q32_empty", 64'(q32.size()), 64'd0);
    chk("q64_empty", 64'(q64.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_avalon_lsu.md
Name: mips_avalon_lsu

Overview:
Parametrised load/store bus unit between the MIPS core datapath and the Avalon memory-mapped master port. It accepts one memory request at a time from the core and issues one Avalon read or write. It handles waitrequest stalls and generates byte-lane byteenables for byte, half, word and (when DATA_W=64) doubleword accesses. It returns sign- or zero-extended load data, and flags misaligned accesses and bus timeouts as errors instead of hanging the core.

Parameters:
ADDR_W, 32, byte address width.
DATA_W, 32, bus data width; legal values 32 or 64; BE_W = DATA_W/8, LANE_W = log2(BE_W).
TIMEOUT, 256, maximum number of waitrequest-high cycles before an error response; 0 disables the timeout.

Ports:
clk  in  1  single clock, all state updates on its rising edge.
reset  in  1  asynchronous, active-low reset; asserting it clears all state immediately, with no clock required.
req_valid  in  1  core request strobe.
req_ready  out  1  unit can accept a request; high only in IDLE.
req_write  in  1  1=store, 0=load.
req_size  in  2  access size: 0=byte, 1=half, 2=word, 3=dword (dword legal only when DATA_W=64).
req_signed  in  1  sign-extend the load result (LB/LH/LW-on-64 bit).
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, right-justified.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_err  out  2  0=ok, 1=misaligned, 2=timeout; valid with resp_valid.
busy  out  1  high in every state other than IDLE.
address  out  ADDR_W  Avalon address, lane-aligned (low LANE_W bits are 0).
read  out  1  Avalon read.
write  out  1  Avalon write.
waitrequest  in  1  Avalon slave stall.
writedata  out  DATA_W  store data replicated into the target lanes.
byteenable  out  BE_W  active byte lanes.
readdata  in  DATA_W  Avalon read data, sampled in the cycle where read=1 and waitrequest=0.

Behaviour:
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, read=0, write=0, address=0, writedata=0, byteenable=0, busy=0, req_ready=1, timeout counter=0, state=IDLE.
- FSM states: IDLE, BUS, RESP.
- IDLE: when req_valid=1, register all request fields.
  - If the request is misaligned, go to RESP with err=1. Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0, or size=3 when DATA_W=32.
  - Otherwise go to BUS.
  - req_valid=0 holds IDLE.
- BUS: read=!req_write and write=req_write.
  - address = {addr[ADDR_W-1:LANE_W], LANE_W'b0}.
  - byteenable for a lane offset o = addr[LANE_W-1:0]: byte = 1<<o; half = 2'b11<<o; word = 4'hF<<o; dword = all ones.
  - writedata replicates the low byte, half or word across all lanes.
  - address, byteenable, writedata, read and write stay stable while waitrequest=1.
  - When waitrequest=0, the transfer completes that cycle. For a load, the selected lanes of readdata are shifted down by 8*o and extended per req_signed. Next state is RESP with err=0.
  - Each cycle with waitrequest=1 increments the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT, drop read/write on the next edge and go to RESP with err=2.
- RESP: resp_valid=1 for exactly one cycle, then IDLE with the counter cleared. A new request is accepted only once back in IDLE.
- Latency: a zero-wait access gives resp_valid 2 cycles after acceptance (accept -> BUS -> RESP). Each waitrequest cycle adds 1. A misaligned request gives resp_valid 1 cycle after acceptance and asserts no bus strobe.
- read and write are never both high. Neither is high outside BUS.
- Reset asserted mid-transfer: strobes drop asynchronously, no response is produced, and the unit returns to IDLE.
- req_valid deasserting after acceptance has no effect; the registered copy of the request is used.

Test Plan:
- DATA_W=32, load byte signed at addr 0x1003, readdata=0x80FFFFFF, waitrequest=0 -> byteenable=4'b1000, address=0x1000, resp_rdata=0xFFFFFF80, err=0, resp_valid 2 cycles after accept.
- Store half 0xBEEF at 0x2002, waitrequest high for 3 cycles -> write held 4 cycles with address=0x2000, byteenable=4'b1100, writedata=0xBEEFBEEF stable throughout; resp_valid in cycle 5.
- Load word at 0x0006 -> no read strobe, resp_valid next cycle, err=1, rdata=0.
- TIMEOUT=4, waitrequest stuck high -> read high for exactly 4 cycles, then resp_valid with err=2; the next request is accepted normally.
- DATA_W=64, load half unsigned at 0x...06, readdata[63:48]=0x9ABC -> byteenable=8'hC0, resp_rdata=0x0000_0000_0000_9ABC; size=3 on DATA_W=32 -> err=1.
- Assert reset low mid-BUS with waitrequest=1 -> read=0 immediately without a clock edge, no resp_valid, req_ready=1 after release.
